// File: rtl/adder_fifo_stim_checker.sv
// Purpose: drives operand words into the adder input FIFO, pops result words from its output
//          FIFO and checks each result against a locally generated expected sum.
// Latency: push/pop strobes are combinational from registered state; status outputs update the
//          cycle after the event that changes them.
// Backpressure: pushes stall on in_full or a full scoreboard; pops occur only when out_empty is low.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   start, num_txn, seed    run control; num_txn/seed are sampled on an accepted start
//   in_full/in_wr/in_data   input FIFO write side
//   out_empty/out_rd/out_data  output FIFO read side (first-word-fall-through)
//   busy, done, pass, timeout, err_count, txn_sent, rsp_recv, first_err_data  run status
module adder_fifo_stim_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int SB_AW      = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           num_txn,
    input  logic [7:0]            seed,
    input  logic                  in_full,
    output logic                  in_wr,
    output logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_empty,
    output logic                  out_rd,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [15:0]           txn_sent,
    output logic [15:0]           rsp_recv,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam int                SB_DEPTH    = 1 << SB_AW;
    localparam int                WD_W        = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);
    localparam logic [SB_AW:0]    SB_FULL_CNT = (SB_AW + 1)'(SB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]           num_q;
    logic [7:0]            seed_q;
    logic [15:0]           sent_q;
    logic [15:0]           recv_q;
    logic [15:0]           err_q;
    logic [DATA_WIDTH-1:0] first_err_q;
    logic                  timeout_q;
    logic [WD_W-1:0]       wd_cnt;

    // Expected-value scoreboard: results return in push order, so a plain circular FIFO suffices.
    logic [DATA_WIDTH-1:0] sb_mem [SB_DEPTH];
    logic [SB_AW-1:0]      sb_wr_ptr;
    logic [SB_AW-1:0]      sb_rd_ptr;
    logic [SB_AW:0]        sb_cnt;

    logic                  start_ok;
    logic                  busy_st;
    logic                  sb_empty;
    logic                  sb_full;
    logic [7:0]            op;
    logic [4:0]            sum5;
    logic [DATA_WIDTH-1:0] exp_word;
    logic                  push;
    logic                  pop;
    logic                  sb_pop;
    logic                  mismatch;
    logic                  rsp_err;
    logic                  wd_fire;

    always_comb begin
        start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        busy_st  = (state_q == S_RUN) || (state_q == S_DRAIN);
        sb_empty = (sb_cnt == '0);
        sb_full  = (sb_cnt == SB_FULL_CNT);
        op       = seed_q + sent_q[7:0];
        sum5     = {1'b0, op[3:0]} + {1'b0, op[7:4]};
        exp_word = {{(DATA_WIDTH-5){1'b0}}, sum5};
        // Strobes are gated by reset_n so a reset cycle never disturbs the external FIFOs.
        push     = reset_n && (state_q == S_RUN) && !in_full && (sent_q < num_q) && !sb_full;
        pop      = reset_n && busy_st && !out_empty;
        sb_pop   = pop && !sb_empty;
        mismatch = sb_pop && (out_data != sb_mem[sb_rd_ptr]);
        // A word arriving with nothing outstanding is an error even if a push lands this cycle.
        rsp_err  = mismatch || (pop && sb_empty);
        wd_fire  = busy_st && !pop && !sb_empty && (wd_cnt == WD_LAST);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = (num_txn != 16'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (wd_fire) begin
                    state_d = S_DONE;
                end else if (sent_q == num_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wd_fire) begin
                    state_d = S_DONE;
                end else if (recv_q >= num_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            num_q       <= '0;
            seed_q      <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            wd_cnt      <= '0;
            sb_wr_ptr   <= '0;
            sb_rd_ptr   <= '0;
            sb_cnt      <= '0;
        end else if (start_ok) begin
            num_q       <= num_txn;
            seed_q      <= seed;
            sent_q      <= '0;
            recv_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            wd_cnt      <= '0;
            sb_wr_ptr   <= '0;
            sb_rd_ptr   <= '0;
            sb_cnt      <= '0;
        end else begin
            if (push) begin
                sent_q    <= sent_q + 16'd1;
                sb_wr_ptr <= sb_wr_ptr + SB_AW'(1);
            end
            if (pop) begin
                recv_q <= recv_q + 16'd1;
                if (rsp_err && (err_q != 16'hFFFF)) begin
                    err_q <= err_q + 16'd1;
                end
                if (mismatch && (err_q == 16'd0)) begin
                    first_err_q <= out_data;
                end
            end
            if (sb_pop) begin
                sb_rd_ptr <= sb_rd_ptr + SB_AW'(1);
            end
            case ({push, sb_pop})
                2'b10:   sb_cnt <= sb_cnt + (SB_AW + 1)'(1);
                2'b01:   sb_cnt <= sb_cnt - (SB_AW + 1)'(1);
                default: sb_cnt <= sb_cnt;
            endcase
            // Watchdog only measures silence while something is actually owed to us.
            if (pop || sb_empty) begin
                wd_cnt <= '0;
            end else if (busy_st) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            sb_mem[sb_wr_ptr] <= exp_word;
        end
    end

    assign in_wr          = push;
    assign in_data        = {{(DATA_WIDTH-8){1'b0}}, op};
    assign out_rd         = pop;
    assign busy           = busy_st;
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == 16'd0) && !timeout_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign txn_sent       = sent_q;
    assign rsp_recv       = recv_q;
    assign first_err_data = first_err_q;

endmodule
